// File: rtl/seq_mult_bcd_if.sv
// Request/result bundle for seq_mult_bcd; the result widths follow from the operand width N.
interface seq_mult_bcd_if #(
  parameter int N = 5
);
  localparam int PW = 2 * N;
  localparam int BW = ((2 * N) / 3 + 1) * 4;

  // Handshake: start is taken only on an edge where busy=0 (FSM idle). a_in, b_in and
  // signed_in are sampled on that same edge and may change freely afterwards. finish
  // pulses for one cycle with out/neg/bcd valid, and those hold until the next finish.
  logic          start;
  logic          signed_in;
  logic [N-1:0]  a_in;
  logic [N-1:0]  b_in;
  logic          busy;
  logic          finish;
  logic [PW-1:0] out;
  logic          neg;
  logic [BW-1:0] bcd;
  logic [1:0]    state_dbg;

  modport master (
    output start, signed_in, a_in, b_in,
    input  busy, finish, out, neg, bcd, state_dbg
  );

  modport slave (
    input  start, signed_in, a_in, b_in,
    output busy, finish, out, neg, bcd, state_dbg
  );
endinterface

// File: rtl/seq_mult_bcd.sv
// Shift-add multiplier (signed/unsigned) with a sequential double-dabble BCD stage.
// Define SEQ_MULT_BCD_CONV_EN to build the BCD converter; without it bcd is tied to 0.
module seq_mult_bcd #(
  parameter int N = 5
) (
  input  logic          clk,
  input  logic          reset,
  seq_mult_bcd_if.slave bus
);
  localparam int PW = 2 * N;
  localparam int BW = ((2 * N) / 3 + 1) * 4;
  localparam int CW = $clog2(PW + 1);
  localparam logic [CW-1:0] N_CNT   = CW'(N);
  localparam logic [CW-1:0] PW_LAST = CW'(PW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic          sign;
  logic [PW-1:0] acc;
  logic [N:0]    psum;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [PW-1:0] out_r;
  logic          neg_r;

`ifdef SEQ_MULT_BCD_CONV_EN
  logic [PW-1:0] bin_sr;
  logic [BW-1:0] digits;
  logic [BW-1:0] dd_next;
  logic [BW-1:0] adj;
  logic [BW-1:0] bcd_r;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = MUL;
      MUL: begin
        if (cnt == N_CNT) begin
`ifdef SEQ_MULT_BCD_CONV_EN
          state_nxt = CONV;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef SEQ_MULT_BCD_CONV_EN
      CONV: if (cnt == PW_LAST) state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // -(-2^(N-1)) wraps to 2^(N-1), which is the correct unsigned N-bit magnitude.
  always_comb begin
    a_mag = (bus.signed_in && bus.a_in[N-1]) ? -bus.a_in : bus.a_in;
    b_mag = (bus.signed_in && bus.b_in[N-1]) ? -bus.b_in : bus.b_in;
    psum  = mplier[0] ? ({1'b0, acc[PW-1:N]} + {1'b0, mcand}) : {1'b0, acc[PW-1:N]};
  end

`ifdef SEQ_MULT_BCD_CONV_EN
  always_comb begin
    adj = digits;
    for (int i = 0; i < BW / 4; i++) begin
      if (digits[4*i +: 4] >= 4'd5) adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
    end
    dd_next = {adj[BW-2:0], bin_sr[PW-1]};
  end
`endif

  // The MUL cycle with cnt == N moves the finished product on rather than iterating.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      sign   <= 1'b0;
      acc    <= '0;
      out_r  <= '0;
      neg_r  <= 1'b0;
`ifdef SEQ_MULT_BCD_CONV_EN
      bin_sr <= '0;
      digits <= '0;
      bcd_r  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            sign   <= bus.signed_in & (bus.a_in[N-1] ^ bus.b_in[N-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          if (cnt == N_CNT) begin
            cnt <= '0;
`ifdef SEQ_MULT_BCD_CONV_EN
            bin_sr <= acc;
            digits <= '0;
`else
            out_r <= sign ? -acc : acc;
            neg_r <= sign & (acc != '0);
`endif
          end else begin
            acc    <= {psum, acc[N-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
`ifdef SEQ_MULT_BCD_CONV_EN
        CONV: begin
          digits <= dd_next;
          bin_sr <= bin_sr << 1;
          cnt    <= cnt + CW'(1);
          if (cnt == PW_LAST) begin
            out_r <= sign ? -acc : acc;
            neg_r <= sign & (acc != '0);
            bcd_r <= dd_next;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.finish    = (state == DONE);
  assign bus.out       = out_r;
  assign bus.neg       = neg_r;
  assign bus.state_dbg = state;
`ifdef SEQ_MULT_BCD_CONV_EN
  assign bus.bcd = bcd_r;
`else
  assign bus.bcd = '0;
`endif
endmodule

// File: tb/tb_seq_mult_bcd.sv
// Bench for seq_mult_bcd: arithmetic reference model with a per-cycle compare, directed
// cases from the test plan, then randomized traffic with occasional resets.
module tb_seq_mult_bcd;
  localparam int N  = 5;
  localparam int PW = 2 * N;
  localparam int BW = ((2 * N) / 3 + 1) * 4;
  localparam int W  = PW + 1 + BW;
`ifdef SEQ_MULT_BCD_CONV_EN
  localparam int LAT    = N + PW + 1;
  localparam bit BCD_ON = 1'b1;
`else
  localparam int LAT    = N + 1;
  localparam bit BCD_ON = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_mult_bcd_if #(.N(N)) bus ();
  seq_mult_bcd #(.N(N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] bcd_lit(input logic [BW-1:0] v);
    return BCD_ON ? v : '0;
  endfunction

  // reference: plain integer product, decimal digits by repeated division
  function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic s);
    int av, bv, p, m;
    logic [BW-1:0] d;
    av = int'(a);
    bv = int'(b);
    if (s && a[N-1]) av -= (1 << N);
    if (s && b[N-1]) bv -= (1 << N);
    p = av * bv;
    m = (p < 0) ? -p : p;
    d = '0;
    for (int i = 0; i < BW / 4; i++) begin
      d[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    if (!BCD_ON) d = '0;
    return {PW'(p), (p < 0), d};
  endfunction

  // scoreboard: an accepted start queues its result, released LAT edges later
  logic [W-1:0]  exp_q[$];
  int            since   = -1;
  bit            armed   = 1'b0;
  logic [PW-1:0] exp_out = '0;
  logic          exp_neg = 1'b0;
  logic [BW-1:0] exp_bcd = '0;

  always @(posedge clk) begin
    if (reset) begin
      armed   = 1'b1;
      since   = -1;
      exp_q.delete();
      exp_out = '0;
      exp_neg = 1'b0;
      exp_bcd = '0;
    end else if (since < 0) begin
      if (bus.start) begin
        since = 0;
        exp_q.push_back(model(bus.a_in, bus.b_in, bus.signed_in));
      end
    end else begin
      since++;
      if (since == LAT) {exp_out, exp_neg, exp_bcd} = exp_q.pop_front();
      else if (since == LAT + 1) since = -1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy",   32'(bus.busy),   32'(since >= 0));
      check("finish", 32'(bus.finish), 32'(since == LAT));
      check("out",    32'(bus.out),    32'(exp_out));
      check("neg",    32'(bus.neg),    32'(exp_neg));
      check("bcd",    32'(bus.bcd),    32'(exp_bcd));
    end
  end

  // driver tasks; each starts and ends on a negedge with the DUT idle
  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic s, input logic [PW-1:0] e_out, input logic e_neg,
                        input logic [BW-1:0] e_bcd, input bit poke);
    int cyc = 0;
    bit got = 1'b0;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.signed_in = s;
    bus.start     = 1'b1;
    @(posedge clk);
    while (!got && cyc <= LAT + 4) begin
      @(negedge clk);
      if (bus.finish) got = 1'b1;
      else begin
        bus.start     = poke && (cyc == 2);
        bus.a_in      = N'($urandom);
        bus.b_in      = N'($urandom);
        bus.signed_in = 1'($urandom_range(0, 1));
        @(posedge clk);
        cyc++;
      end
    end
    check({name, " done"},    32'(got),   32'd1);
    check({name, " latency"}, 32'(cyc),   32'(LAT));
    check({name, " out"},     32'(bus.out), 32'(e_out));
    check({name, " neg"},     32'(bus.neg), 32'(e_neg));
    check({name, " bcd"},     32'(bus.bcd), 32'(e_bcd));
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_held();
    int cyc = 0;
    int f1  = -1;
    int f2  = -1;
    bus.a_in      = 5'd13;
    bus.b_in      = 5'd13;
    bus.signed_in = 1'b0;
    bus.start     = 1'b1;
    while (f2 < 0 && cyc < 2 * LAT + 10) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.finish) begin
        if (f1 < 0) begin
          f1 = cyc;
          check("held first out", 32'(bus.out), 32'd169);
        end else begin
          f2 = cyc;
          bus.start = 1'b0;
          check("held second out", 32'(bus.out), 32'd169);
          check("held second bcd", 32'(bus.bcd), 32'(bcd_lit(16'h0169)));
        end
      end else if (f1 >= 0 && cyc == f1 + 2) begin
        check("held busy again", 32'(bus.busy), 32'd1);
        check("held out kept",   32'(bus.out),  32'd169);
      end
    end
    bus.start = 1'b0;
    check("held second seen", 32'(f2 >= 0), 32'd1);
    check("held gap", 32'(f2 - f1), 32'(LAT + 2));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_reset_mid();
    int fins = 0;
    bus.a_in      = 5'd31;
    bus.b_in      = 5'd31;
    bus.signed_in = 1'b0;
    bus.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid reset busy",   32'(bus.busy),   32'd0);
    check("mid reset finish", 32'(bus.finish), 32'd0);
    check("mid reset out",    32'(bus.out),    32'd0);
    check("mid reset neg",    32'(bus.neg),    32'd0);
    check("mid reset bcd",    32'(bus.bcd),    32'd0);
    repeat (LAT + 4) begin
      @(negedge clk);
      if (bus.finish) fins++;
    end
    check("mid reset no finish", 32'(fins), 32'd0);
  endtask

  function automatic logic [N-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return N'(1) << (N - 1);
      3:       return N'(1);
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    bus.start     = 1'b0;
    bus.signed_in = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    reset         = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset busy",   32'(bus.busy),   32'd0);
    check("reset finish", 32'(bus.finish), 32'd0);
    check("reset out",    32'(bus.out),    32'd0);
    check("reset neg",    32'(bus.neg),    32'd0);
    check("reset bcd",    32'(bus.bcd),    32'd0);

    check("model u26x30", 32'(model(5'd26, 5'd30, 1'b0)),
          32'({10'd780, 1'b0, bcd_lit(16'h0780)}));
    check("model s-3x7", 32'(model(5'b11101, 5'b00111, 1'b1)),
          32'({10'h3EB, 1'b1, bcd_lit(16'h0021)}));
    check("model s-1x-1", 32'(model(5'h1F, 5'h1F, 1'b1)),
          32'({10'd1, 1'b0, bcd_lit(16'h0001)}));

    run_op("u26x30",   5'd26,    5'd30,    1'b0, 10'd780, 1'b0, bcd_lit(16'h0780), 1'b0);
    run_op("s-3x7",    5'b11101, 5'b00111, 1'b1, 10'h3EB, 1'b1, bcd_lit(16'h0021), 1'b0);
    run_op("s-16x-16", 5'b10000, 5'b10000, 1'b1, 10'd256, 1'b0, bcd_lit(16'h0256), 1'b0);
    run_op("u31x31",   5'd31,    5'd31,    1'b0, 10'd961, 1'b0, bcd_lit(16'h0961), 1'b0);
    run_op("u0x31",    5'd0,     5'd31,    1'b0, 10'd0,   1'b0, 16'h0000,          1'b0);
    run_op("s-4x0",    5'b11100, 5'd0,     1'b1, 10'd0,   1'b0, 16'h0000,          1'b0);
    run_op("poke",     5'd26,    5'd30,    1'b0, 10'd780, 1'b0, bcd_lit(16'h0780), 1'b1);
    run_held();
    run_reset_mid();
    run_op("after reset", 5'd7,  5'd9,     1'b0, 10'd63,  1'b0, bcd_lit(16'h0063), 1'b0);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset         = ($urandom_range(0, 399) == 0);
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.signed_in = 1'($urandom_range(0, 1));
      bus.a_in      = rnd_operand();
      bus.b_in      = rnd_operand();
    end
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    check("queue drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
